uart_receive: RTL and testbench
===============================

UART_RECEIVE -- requirements
Module: uart_receive

Interface
REQ-001 SHALL have parameter INPUT_CLOCK_FREQ, default 100_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 9600, serial bit rate; P = INPUT_CLOCK_FREQ/BAUD_RATE (integer division), H = P/2.
REQ-003 SHALL have port clk_in, input, 1, the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n_in, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port rx_wire_in, input, 1, asynchronous serial line; idle high, 8N1, LSB first.
REQ-006 SHALL have port data_byte_out, output, 8, last correctly framed byte.
REQ-007 SHALL have port new_data_out, output, 1, one-cycle pulse when data_byte_out updates.
REQ-008 SHALL have port framing_error_out, output, 1, one-cycle pulse on invalid stop bit.
REQ-009 SHALL have port busy_out, output, 1, high whenever the state is not IDLE.

Function
REQ-010 SHALL pass rx_wire_in through a 2-flop synchronizer (reset value 1); "rx" below means the synchronized value.
REQ-011 SHALL implement states IDLE, START, DATA, STOP, WAIT_HIGH.
REQ-012 IDLE: on rx==0, SHALL go to START and clear the bit counter (cycle count 0 = first cycle rx seen low).
REQ-013 START: at count H-1, SHALL sample rx; if 1 (glitch), return to IDLE with no output; if 0, go to DATA and restart count.
REQ-014 DATA: SHALL sample at every count P-1, shift the sample into bit position 0..7 in order (LSB first), and go to STOP after the 8th sample.
REQ-015 STOP: at count P-1, SHALL sample rx; if 1, load data_byte_out and pulse new_data_out on the next cycle, then go to IDLE.
REQ-016 STOP: if the sample is 0, SHALL pulse framing_error_out on the next cycle, leave data_byte_out unchanged, and go to WAIT_HIGH.
REQ-017 WAIT_HIGH: SHALL stay until rx==1, then go to IDLE; a held-low (break) line SHALL produce no further output.
REQ-018 Stop-sample time SHALL be 9*P+H-1 cycles after start detection; IDLE SHALL be re-entered before the stop bit ends, so back-to-back frames are accepted.
REQ-019 new_data_out and framing_error_out SHALL never be high in the same cycle, and each SHALL be high for exactly one cycle per frame.
REQ-020 The counter SHALL be $clog2(P) bits wide and SHALL never exceed P-1.
REQ-021 rx_wire_in transitions during DATA SHALL NOT alter sampling timing (no resynchronization mid-frame).

Reset
REQ-022 While rst_n_in==0, SHALL force state IDLE, data_byte_out=0, new_data_out=0, framing_error_out=0, busy_out=0, synchronizer flops=1, and counters=0.
REQ-023 Reset asserted mid-frame SHALL abort the frame with no output pulse; after release, reception SHALL resume only at the next falling edge seen in IDLE.

Configuration
REQ-024 Macro UART_RX_MAJORITY_VOTE_EN: when defined, each sample (start, data, stop) SHALL be the 2-of-3 majority of rx at counts K-1, K and K+1, where K is the nominal sample count; the decision and any state change SHALL occur at count K+1, and all later samples SHALL keep nominal spacing P.
REQ-025 When UART_RX_MAJORITY_VOTE_EN is not defined, SHALL take a single sample of rx at the nominal count with no extra logic.

Verification (P=10416, H=5208)
REQ-026 Frame 0xA5 driven at exact P -> data_byte_out=0xA5 and one new_data_out pulse 9*P+H+2 cycles after the falling edge (synchronizer included); framing_error_out stays 0.
REQ-027 Low glitch of 2000 cycles on an idle line -> return to IDLE, no pulses, data_byte_out unchanged.
REQ-028 Frame 0x3C with stop bit 0, then line held low 3*P -> one framing_error_out pulse, data_byte_out keeps the prior value, busy_out stays 1 until the line goes high.
REQ-029 Back-to-back 0x00, 0xFF, 0x55 with no idle gap, driven by uart_transmit in loopback -> three new_data_out pulses with the matching bytes.
REQ-030 rst_n_in pulsed low at bit 4 of frame 0x81 -> all outputs 0 immediately; the next full frame 0x42 is received correctly.
REQ-031 With UART_RX_MAJORITY_VOTE_EN defined, a single-cycle inverted spike at each data-bit centre of 0x96 -> 0x96 is still received.

Source files
------------

// File: rtl/uart_receive.sv
`default_nettype none
// ============================================================================
// Module   : uart_receive
// Purpose  : 8N1 UART receiver with 2-flop input synchronizer, start-glitch
//            rejection, framing-error detection and break (held-low) handling.
// Options  : define UART_RX_MAJORITY_VOTE_EN for 2-of-3 majority sampling.
// Revision : 1.0  initial release
// ============================================================================
module uart_receive #(
    parameter int INPUT_CLOCK_FREQ = 100_000_000,
    parameter int BAUD_RATE        = 9600
) (
    input  logic       clk_in,
    input  logic       rst_n_in,
    input  logic       rx_wire_in,
    output logic [7:0] data_byte_out,
    output logic       new_data_out,
    output logic       framing_error_out,
    output logic       busy_out
);

    localparam int c_P     = INPUT_CLOCK_FREQ / BAUD_RATE;
    localparam int c_H     = c_P / 2;
    localparam int c_CNT_W = (c_P > 1) ? $clog2(c_P) : 1;

    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(c_P - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);

`ifdef UART_RX_MAJORITY_VOTE_EN
    // Decisions land one count after the nominal point; the free-running
    // modulo-P count keeps every later decision exactly P cycles apart.
    localparam logic [c_CNT_W-1:0] c_START_DEC  = c_CNT_W'(c_H);
    localparam logic [c_CNT_W-1:0] c_BIT_DEC    = c_CNT_W'(0);
    localparam logic [c_CNT_W-1:0] c_RESTART    = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0] c_START_CAP0 = c_CNT_W'(c_H - 2);
    localparam logic [c_CNT_W-1:0] c_START_CAP1 = c_CNT_W'(c_H - 1);
    localparam logic [c_CNT_W-1:0] c_BIT_CAP0   = c_CNT_W'(c_P - 2);
    localparam logic [c_CNT_W-1:0] c_BIT_CAP1   = c_CNT_W'(c_P - 1);
`else
    localparam logic [c_CNT_W-1:0] c_START_DEC  = c_CNT_W'(c_H - 1);
    localparam logic [c_CNT_W-1:0] c_BIT_DEC    = c_CNT_W'(c_P - 1);
    localparam logic [c_CNT_W-1:0] c_RESTART    = c_CNT_W'(0);
`endif

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_STOP      = 3'd3,
        ST_WAIT_HIGH = 3'd4
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic                 r_rx_meta;
    logic                 r_rx_sync;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [c_CNT_W-1:0]   w_cnt_next;
    logic [2:0]           r_bit_idx;
    logic [7:0]           r_shift;
    logic [7:0]           r_data;
    logic                 r_new_data;
    logic                 r_ferr;
    logic                 w_sample;
    logic                 w_dec;
    logic                 w_load;
    logic                 w_ferr;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
        end else begin
            r_rx_meta <= rx_wire_in;
            r_rx_sync <= r_rx_meta;
        end
    end

`ifdef UART_RX_MAJORITY_VOTE_EN
    logic r_vote0;
    logic r_vote1;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_vote0 <= 1'b1;
            r_vote1 <= 1'b1;
        end else if (r_state == ST_START) begin
            if (r_cnt == c_START_CAP0) r_vote0 <= r_rx_sync;
            if (r_cnt == c_START_CAP1) r_vote1 <= r_rx_sync;
        end else if (r_state == ST_DATA || r_state == ST_STOP) begin
            if (r_cnt == c_BIT_CAP0) r_vote0 <= r_rx_sync;
            if (r_cnt == c_BIT_CAP1) r_vote1 <= r_rx_sync;
        end
    end

    assign w_sample = (r_vote0 & r_vote1) | (r_vote0 & r_rx_sync) | (r_vote1 & r_rx_sync);
`else
    assign w_sample = r_rx_sync;
`endif

    always_comb begin
        w_dec = 1'b0;
        case (r_state)
            ST_START: w_dec = (r_cnt == c_START_DEC);
            ST_DATA,
            ST_STOP:  w_dec = (r_cnt == c_BIT_DEC);
            default:  w_dec = 1'b0;
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = '0;
        w_load       = 1'b0;
        w_ferr       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // The cycle rx is first seen low is count 0.
                if (!r_rx_sync) begin
                    w_state_next = ST_START;
                    w_cnt_next   = c_CNT_ONE;
                end
            end
            ST_START: begin
                w_cnt_next = r_cnt + c_CNT_ONE;
                if (w_dec) begin
                    w_cnt_next   = c_RESTART;
                    w_state_next = w_sample ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                w_cnt_next = (r_cnt == c_CNT_MAX) ? '0 : r_cnt + c_CNT_ONE;
                if (w_dec && r_bit_idx == 3'd7) begin
                    w_state_next = ST_STOP;
                end
            end
            ST_STOP: begin
                w_cnt_next = (r_cnt == c_CNT_MAX) ? '0 : r_cnt + c_CNT_ONE;
                if (w_dec) begin
                    w_cnt_next   = '0;
                    w_load       = w_sample;
                    w_ferr       = ~w_sample;
                    w_state_next = w_sample ? ST_IDLE : ST_WAIT_HIGH;
                end
            end
            ST_WAIT_HIGH: begin
                if (r_rx_sync) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_bit_idx  <= 3'd0;
            r_shift    <= 8'h00;
            r_data     <= 8'h00;
            r_new_data <= 1'b0;
            r_ferr     <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_cnt      <= w_cnt_next;
            r_new_data <= w_load;
            r_ferr     <= w_ferr;
            if (r_state == ST_START && w_dec) begin
                r_bit_idx <= 3'd0;
            end else if (r_state == ST_DATA && w_dec) begin
                r_shift   <= {w_sample, r_shift[7:1]};
                r_bit_idx <= r_bit_idx + 3'd1;
            end
            if (w_load) begin
                r_data <= r_shift;
            end
        end
    end

    assign data_byte_out     = r_data;
    assign new_data_out      = r_new_data;
    assign framing_error_out = r_ferr;
    assign busy_out          = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_receive.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_receive
// Purpose  : Directed, table-driven bench for uart_receive (P=16, H=8).
// Revision : 1.0  initial release
// ============================================================================
module tb_uart_receive;

    localparam int c_FREQ = 160;
    localparam int c_BAUD = 10;
    localparam int c_P    = 16;
    localparam int c_H    = 8;
`ifdef UART_RX_MAJORITY_VOTE_EN
    localparam int c_LAT  = 9 * c_P + c_H + 3;
`else
    localparam int c_LAT  = 9 * c_P + c_H + 2;
`endif

    logic       clk_in     = 1'b0;
    logic       rst_n_in   = 1'b0;
    logic       rx_wire_in = 1'b1;
    logic [7:0] data_byte_out;
    logic       new_data_out;
    logic       framing_error_out;
    logic       busy_out;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int fall_cyc     = 0;
    int last_new_cyc = 0;
    int n_new  = 0;
    int n_ferr = 0;
    int n_both = 0;
    logic [7:0] rx_q[$];

    uart_receive #(
        .INPUT_CLOCK_FREQ(c_FREQ),
        .BAUD_RATE       (c_BAUD)
    ) dut (
        .clk_in           (clk_in),
        .rst_n_in         (rst_n_in),
        .rx_wire_in       (rx_wire_in),
        .data_byte_out    (data_byte_out),
        .new_data_out     (new_data_out),
        .framing_error_out(framing_error_out),
        .busy_out         (busy_out)
    );

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) cyc <= cyc + 1;

    always @(negedge clk_in) begin
        if (new_data_out === 1'b1) begin
            n_new++;
            last_new_cyc = cyc;
            rx_q.push_back(data_byte_out);
        end
        if (framing_error_out === 1'b1) n_ferr++;
        if (new_data_out === 1'b1 && framing_error_out === 1'b1) n_both++;
    end

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic [7:0] exp_data;
        int         exp_new;
        int         exp_ferr;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic drive_bit(input logic b, input int n);
        rx_wire_in = b;
        repeat (n) @(negedge clk_in);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input int gap);
        fall_cyc = cyc;
        drive_bit(1'b0, c_P);
        for (int i = 0; i < 8; i++) drive_bit(d[i], c_P);
        drive_bit(stop, c_P);
        if (gap > 0) drive_bit(1'b1, gap);
    endtask

`ifdef UART_RX_MAJORITY_VOTE_EN
    task automatic send_spiky(input logic [7:0] d);
        drive_bit(1'b0, c_P);
        for (int i = 0; i < 8; i++) begin
            drive_bit(d[i], c_H);
            drive_bit(~d[i], 1);
            drive_bit(d[i], c_P - c_H - 1);
        end
        drive_bit(1'b1, 3 * c_P);
    endtask
`endif

    initial begin
        int b_new;
        int b_ferr;
        logic [7:0] exp_b2b[3];
        logic [7:0] got;

        vecs[0] = '{8'hA5, 1'b1, 8'hA5, 1, 0};
        vecs[1] = '{8'h3C, 1'b0, 8'hA5, 0, 1};
        vecs[2] = '{8'h00, 1'b1, 8'h00, 1, 0};
        vecs[3] = '{8'hFF, 1'b1, 8'hFF, 1, 0};
        vecs[4] = '{8'h3C, 1'b0, 8'hFF, 0, 1};
        vecs[5] = '{8'h81, 1'b1, 8'h81, 1, 0};
        exp_b2b[0] = 8'h00;
        exp_b2b[1] = 8'hFF;
        exp_b2b[2] = 8'h55;

        repeat (3) @(negedge clk_in);
        check("reset_data",  {24'h0, data_byte_out}, 32'h00);
        check("reset_new",   {31'h0, new_data_out}, 32'h0);
        check("reset_ferr",  {31'h0, framing_error_out}, 32'h0);
        check("reset_busy",  {31'h0, busy_out}, 32'h0);
        rst_n_in = 1'b1;
        repeat (3) @(negedge clk_in);

        // First frame: exact latency from line falling edge to new_data pulse
        b_new  = n_new;
        b_ferr = n_ferr;
        send_frame(8'hA5, 1'b1, 2 * c_P);
        check("lat_pulses", n_new - b_new, 1);
        check("lat_cycles", last_new_cyc - fall_cyc, c_LAT);
        check("lat_data",   {24'h0, data_byte_out}, 32'hA5);
        check("lat_ferr",   n_ferr - b_ferr, 0);

        for (int v = 0; v < 6; v++) begin
            b_new  = n_new;
            b_ferr = n_ferr;
            send_frame(vecs[v].data, vecs[v].stop, 2 * c_P);
            check($sformatf("vec%0d_new", v),  n_new - b_new, vecs[v].exp_new);
            check($sformatf("vec%0d_ferr", v), n_ferr - b_ferr, vecs[v].exp_ferr);
            check($sformatf("vec%0d_data", v), {24'h0, data_byte_out}, {24'h0, vecs[v].exp_data});
            check($sformatf("vec%0d_idle", v), {31'h0, busy_out}, 32'h0);
        end

        // Start glitch shorter than half a bit
        b_new  = n_new;
        b_ferr = n_ferr;
        rx_wire_in = 1'b0;
        repeat (4) @(negedge clk_in);
        check("glitch_busy", {31'h0, busy_out}, 32'h1);
        repeat (1) @(negedge clk_in);
        drive_bit(1'b1, 2 * c_P);
        check("glitch_idle", {31'h0, busy_out}, 32'h0);
        check("glitch_pulses", (n_new - b_new) + (n_ferr - b_ferr), 0);
        check("glitch_data", {24'h0, data_byte_out}, 32'h81);

        // Bad stop bit followed by a break
        b_new  = n_new;
        b_ferr = n_ferr;
        send_frame(8'h3C, 1'b0, 0);
        drive_bit(1'b0, 3 * c_P);
        check("break_busy", {31'h0, busy_out}, 32'h1);
        check("break_ferr", n_ferr - b_ferr, 1);
        check("break_data", {24'h0, data_byte_out}, 32'h81);
        drive_bit(1'b1, 2 * c_P);
        check("break_release", {31'h0, busy_out}, 32'h0);
        check("break_ferr_once", n_ferr - b_ferr, 1);
        check("break_no_new", n_new - b_new, 0);

        // Back-to-back frames with no idle gap
        rx_q.delete();
        b_ferr = n_ferr;
        send_frame(8'h00, 1'b1, 0);
        send_frame(8'hFF, 1'b1, 0);
        send_frame(8'h55, 1'b1, 2 * c_P);
        check("b2b_count", rx_q.size(), 3);
        for (int i = 0; i < 3; i++) begin
            got = (i < rx_q.size()) ? rx_q[i] : 8'hxx;
            check($sformatf("b2b_byte%0d", i), {24'h0, got}, {24'h0, exp_b2b[i]});
        end
        check("b2b_ferr", n_ferr - b_ferr, 0);

        // Reset asserted in the middle of a frame
        b_new  = n_new;
        b_ferr = n_ferr;
        fork
            send_frame(8'h81, 1'b1, 0);
            begin
                repeat (5 * c_P + c_H) @(negedge clk_in);
                check("rst_mid_busy_before", {31'h0, busy_out}, 32'h1);
                rst_n_in = 1'b0;
                #1;
                check("rst_mid_data", {24'h0, data_byte_out}, 32'h00);
                check("rst_mid_busy", {31'h0, busy_out}, 32'h0);
                check("rst_mid_new",  {31'h0, new_data_out}, 32'h0);
                check("rst_mid_ferr", {31'h0, framing_error_out}, 32'h0);
                repeat (4 * c_P) @(negedge clk_in);
                rst_n_in = 1'b1;
            end
        join
        drive_bit(1'b1, 2 * c_P);
        check("rst_mid_no_pulse", (n_new - b_new) + (n_ferr - b_ferr), 0);
        send_frame(8'h42, 1'b1, 2 * c_P);
        check("rst_after_new",  n_new - b_new, 1);
        check("rst_after_data", {24'h0, data_byte_out}, 32'h42);

`ifdef UART_RX_MAJORITY_VOTE_EN
        b_new = n_new;
        send_spiky(8'h96);
        check("vote_new",  n_new - b_new, 1);
        check("vote_data", {24'h0, data_byte_out}, 32'h96);
`endif

        check("pulse_exclusive", n_both, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
